// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types, ALU opcodes and class helpers for the multi-cycle sequencer
package mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_FP,
        CLS_VEC
    } class_e;

    // FP class; 1100 is also MOVIDX, which runs on the FP unit
    localparam logic [3:0] ALU_FMUL = 4'b0101;
    localparam logic [3:0] ALU_FADD = 4'b1100;
    localparam logic [3:0] ALU_FDIV = 4'b1101;

    localparam logic [3:0] ALU_VADD = 4'b1000;
    localparam logic [3:0] ALU_VSUB = 4'b1001;
    localparam logic [3:0] ALU_VMUL = 4'b1010;
    localparam logic [3:0] ALU_VAND = 4'b1011;
    localparam logic [3:0] ALU_VXOR = 4'b1111;

    function automatic logic is_fp(input logic [3:0] alu_control);
        return (alu_control == ALU_FMUL) || (alu_control == ALU_FADD) ||
               (alu_control == ALU_FDIV);
    endfunction

    function automatic logic is_vec(input logic [3:0] alu_control);
        return (alu_control == ALU_VADD) || (alu_control == ALU_VSUB) ||
               (alu_control == ALU_VMUL) || (alu_control == ALU_VAND) ||
               (alu_control == ALU_VXOR);
    endfunction

endpackage

// File: rtl/multicycle_exec_ctrl_if.sv
// rtl/multicycle_exec_ctrl_if.sv - decoder/multi-cycle-unit handshake bundle for the sequencer
interface multicycle_exec_ctrl_if;

    logic        InstrValid;
    logic        ALUOp;
    logic [3:0]  ALUControl;
    logic        MCDone;
    logic        MCStart;
    logic        Stall;
    logic        CommitEn;
    logic        MCError;
    logic [15:0] StallCount;

    modport master (
        output InstrValid, ALUOp, ALUControl, MCDone,
        input  MCStart, Stall, CommitEn, MCError, StallCount
    );

    modport slave (
        input  InstrValid, ALUOp, ALUControl, MCDone,
        output MCStart, Stall, CommitEn, MCError, StallCount
    );

endinterface

// File: rtl/mc_latency_counter.sv
// rtl/mc_latency_counter.sv - minimum-latency down counter: load, decrement, hold at zero
module mc_latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] lat_q, lat_d;

    always_comb begin
        lat_d = lat_q;
        if (load_i) begin
            lat_d = load_val_i;
        end else if (dec_i && (lat_q != '0)) begin
            lat_d = lat_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end

    assign zero_o = (lat_q == '0);

endmodule

// File: rtl/multicycle_exec_ctrl.sv
// rtl/multicycle_exec_ctrl.sv - multi-cycle FP/vector op sequencer (stall, start, commit, timeout)
// Optional stall-cycle counter built when MC_PERF_COUNT_EN is defined.
module multicycle_exec_ctrl
    import mc_pkg::*;
#(
    parameter int FP_LAT  = 3,
    parameter int VEC_LAT = 2,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_exec_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    class_e           class_q, class_d;
    logic             done_seen_q, done_seen_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    logic             lat_load;
    logic [CNT_W-1:0] lat_load_val;
    logic             lat_dec;
    logic             lat_zero;
    logic             stall;
    logic             commit;
    logic             mc_start;
    logic             op_fp;
    logic             op_vec;

    assign op_fp  = bus.ALUOp && is_fp(bus.ALUControl);
    assign op_vec = bus.ALUOp && is_vec(bus.ALUControl);

    mc_latency_counter #(.CNT_W(CNT_W)) u_lat (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (lat_load),
        .load_val_i (lat_load_val),
        .dec_i      (lat_dec),
        .zero_o     (lat_zero)
    );

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        done_seen_d  = done_seen_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        lat_load     = 1'b0;
        lat_load_val = '0;
        lat_dec      = 1'b0;
        stall        = 1'b0;
        commit       = 1'b0;
        mc_start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.InstrValid && (op_fp || op_vec)) begin
                    stall        = 1'b1;
                    lat_load     = 1'b1;
                    lat_load_val = op_fp ? CNT_W'(FP_LAT) : CNT_W'(VEC_LAT);
                    class_d      = op_fp ? CLS_FP : CLS_VEC;
                    state_d      = ST_ISSUE;
                end else begin
                    commit = bus.InstrValid;
                end
            end
            ST_ISSUE: begin
                // Counting down already here gives exactly LAT cycles in WAIT
                mc_start    = (class_q != CLS_NONE);
                stall       = 1'b1;
                lat_dec     = 1'b1;
                done_seen_d = 1'b0;
                tmo_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                stall       = 1'b1;
                lat_dec     = 1'b1;
                tmo_d       = tmo_q + 1'b1;
                done_seen_d = done_seen_q | bus.MCDone;
                if (lat_zero && (bus.MCDone || done_seen_q)) begin
                    state_d = ST_DONE;
                end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                commit  = 1'b1;
                class_d = CLS_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            class_q     <= CLS_NONE;
            done_seen_q <= 1'b0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            class_q     <= class_d;
            done_seen_q <= done_seen_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end

`ifdef MC_PERF_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.StallCount = stall_cnt_q;
`else
    assign bus.StallCount = 16'h0000;
`endif

    assign bus.MCStart  = mc_start;
    assign bus.Stall    = stall;
    assign bus.CommitEn = commit;
    assign bus.MCError  = err_q;

endmodule

// File: tb/tb_multicycle_exec_ctrl.sv
// tb/tb_multicycle_exec_ctrl.sv - directed self-checking bench for multicycle_exec_ctrl
module tb_multicycle_exec_ctrl;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   stalls, starts, commit_at;
    int   exp_cnt;

    multicycle_exec_ctrl_if bus();

    multicycle_exec_ctrl #(
        .FP_LAT  (3),
        .VEC_LAT (2),
        .TIMEOUT (15),
        .CNT_W   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_idle();
        bus.InstrValid = 1'b0;
        bus.ALUOp      = 1'b0;
        bus.ALUControl = 4'b0000;
        bus.MCDone     = 1'b0;
    endtask

    // Starts at a negedge; returns at the negedge after the commit cycle with idle inputs.
    // InstrValid stays high with an opcode of the other class to show the class is latched.
    task automatic run_op(input logic [3:0] op, input int done_from, input int done_to,
                          output int n_stall, output int n_start, output int commit_c);
        n_stall  = 0;
        n_start  = 0;
        commit_c = -1;
        for (int c = 1; c <= 40; c++) begin
            bus.InstrValid = 1'b1;
            bus.ALUOp      = 1'b1;
            bus.ALUControl = (c == 1) ? op : (is_vec(op) ? ALU_FMUL : ALU_VADD);
            bus.MCDone     = (c >= done_from) && (c <= done_to);
            #1;
            if (bus.Stall)   n_stall++;
            if (bus.MCStart) n_start++;
            if (bus.CommitEn) begin
                commit_c = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic add_commit(input string tag);
        bus.InstrValid = 1'b1;
        bus.ALUOp      = 1'b1;
        bus.ALUControl = 4'b0000;
        #1;
        chk({tag, "_stall"}, 32'(bus.Stall), 0);
        chk({tag, "_commit"}, 32'(bus.CommitEn), 1);
        chk({tag, "_start"}, 32'(bus.MCStart), 0);
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        set_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall",  32'(bus.Stall), 0);
        chk("rst_commit", 32'(bus.CommitEn), 0);
        chk("rst_start",  32'(bus.MCStart), 0);
        chk("rst_err",    32'(bus.MCError), 0);
        chk("rst_cnt",    32'(bus.StallCount), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        add_commit("add");
        #1;
        chk("idle_commit", 32'(bus.CommitEn), 0);
        chk("idle_stall",  32'(bus.Stall), 0);
        @(negedge clk);

        run_op(ALU_FMUL, 1, 40, stalls, starts, commit_at);
        chk("fmul_stalls", 32'(stalls), 5);
        chk("fmul_starts", 32'(starts), 1);
        chk("fmul_commit", 32'(commit_at), 6);

        // MCDone only in WAIT1 while lat is still 1
        run_op(ALU_VADD, 3, 3, stalls, starts, commit_at);
        chk("vadd_stalls", 32'(stalls), 4);
        chk("vadd_starts", 32'(starts), 1);
        chk("vadd_commit", 32'(commit_at), 5);

        // MCDone only in ISSUE is discarded; completes via timeout
        chk("pre_tmo_err", 32'(bus.MCError), 0);
        run_op(ALU_FADD, 2, 2, stalls, starts, commit_at);
        chk("fadd_stalls", 32'(stalls), 17);
        chk("fadd_commit", 32'(commit_at), 18);
        chk("fadd_err",    32'(bus.MCError), 1);
        add_commit("add_after_err");
        #1;
        chk("err_sticky", 32'(bus.MCError), 1);
        @(negedge clk);

        bus.InstrValid = 1'b1;
        bus.ALUOp      = 1'b1;
        bus.ALUControl = ALU_VXOR;
        @(negedge clk);
        bus.InstrValid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("vxor_wait_stall", 32'(bus.Stall), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_stall",  32'(bus.Stall), 0);
        chk("mid_rst_commit", 32'(bus.CommitEn), 0);
        chk("mid_rst_err",    32'(bus.MCError), 0);
        chk("mid_rst_start",  32'(bus.MCStart), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        add_commit("add_after_rst");

        run_op(ALU_FMUL, 1, 40, stalls, starts, commit_at);
        chk("b2b1_commit", 32'(commit_at), 6);
        run_op(ALU_FMUL, 1, 40, stalls, starts, commit_at);
        chk("b2b2_commit", 32'(commit_at), 6);
`ifdef MC_PERF_COUNT_EN
        exp_cnt = 10;
`else
        exp_cnt = 0;
`endif
        #1;
        chk("stall_count", 32'(bus.StallCount), 32'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
